// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side initiator for the 32x32 register file.
// Accepts writeback requests from the load path (mem) and the ALU path over
// valid/ready handshakes. Accepted requests are queued in a DEPTH-entry FIFO
// and drained one per cycle into the registered write port. It also exports a
// pending-write scoreboard for RAW hazard detection.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   alu_valid/ready/reg/data   ALU writeback request (lower priority)
//   mem_valid/ready/reg/data   load writeback request (higher priority)
//   wb_stall                   freezes draining
//   WriteReg/WriteData/RegWrite registered register file write port
//   rd1_addr/rd2_addr          read addresses to check for pending writes
//   rd1_busy/rd2_busy          a queued or in-flight write targets that address
//   fifo_count                 number of queued entries
//   idle                       FIFO empty and no write in flight
module regfile_wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_reg,
    input  logic [31:0]              mem_data,
    input  logic                     wb_stall,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    output logic                     RegWrite,
    input  logic [4:0]               rd1_addr,
    input  logic [4:0]               rd2_addr,
    output logic                     rd1_busy,
    output logic                     rd2_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    ent_reg_q  [DEPTH];
    logic [4:0]    ent_reg_d  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          reg_write_q, reg_write_d;

    logic          full, mem_hs, alu_hs, push, pop;
    logic [4:0]    acc_reg;
    logic [31:0]   acc_data;

    // Ready depends only on the current count: a pop in the same cycle does
    // not open a slot for a push.
    assign full      = (count_q == CW'(DEPTH));
    assign mem_ready = !reset && !full;
    assign alu_ready = !reset && !full && !mem_valid;
    assign mem_hs    = mem_valid && mem_ready;
    assign alu_hs    = alu_valid && alu_ready;
    assign acc_reg   = mem_hs ? mem_reg  : alu_reg;
    assign acc_data  = mem_hs ? mem_data : alu_data;

    // Writes to r0 still complete the handshake but never occupy a slot.
    assign push = (mem_hs || alu_hs) && !(DROP_R0 && acc_reg == 5'd0);
    assign pop  = !wb_stall && (count_q != '0);

    always_comb begin
        ent_reg_d    = ent_reg_q;
        ent_data_d   = ent_data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (pop) begin
            write_reg_d  = ent_reg_q[head_q];
            write_data_d = ent_data_q[head_q];
            reg_write_d  = 1'b1;
            head_d       = head_q + PW'(1);
        end
        if (push) begin
            ent_reg_d[tail_q]  = acc_reg;
            ent_data_d[tail_q] = acc_data;
            tail_d             = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // Scoreboard: live entries are the count_q slots starting at head_q, plus
    // the write currently on the port. Same-cycle acceptances are not visible.
    logic [1:0][4:0] rd_addr;
    logic [1:0]      rd_busy;
    assign rd_addr = {rd2_addr, rd1_addr};

    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q && ent_reg_q[head_q + PW'(i)] == rd_addr[p])
                    rd_busy[p] = 1'b1;
            end
            if (reg_write_q && write_reg_q == rd_addr[p])
                rd_busy[p] = 1'b1;
            if (DROP_R0 && rd_addr[p] == 5'd0)
                rd_busy[p] = 1'b0;
        end
    end

    assign rd1_busy   = rd_busy[0];
    assign rd2_busy   = rd_busy[1];
    assign WriteReg   = write_reg_q;
    assign WriteData  = write_data_q;
    assign RegWrite   = reg_write_q;
    assign fifo_count = count_q;
    assign idle       = (count_q == '0) && !reg_write_q;

endmodule
